// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI slave framer.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        DUMMY,
        READ
    } state_e;

    localparam int unsigned CMD_READ_BIT  = 7;
    localparam logic [7:0]  UNDERRUN_FILL = 8'h00;

    function automatic int unsigned digits_per_byte(input int unsigned dwidth);
        return 8 / dwidth;
    endfunction

endpackage

// File: rtl/qspi_pin_sync.sv
// Synchronises QCK/QSS/QD into clk and reports QCK and QSS edges aligned with the data.
module qspi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       qck_i,
    input  logic       qss_i,
    input  logic [3:0] qd_i,
    output logic       valid_o,
    output logic       qss_o,
    output logic       qrise_o,
    output logic       qfall_o,
    output logic       ss_rise_o,
    output logic [3:0] qd_o
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("qspi_pin_sync: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0]      qck_q;
    logic [SYNC_STAGES-1:0]      qss_q;
    logic [SYNC_STAGES-1:0]      vld_q;
    logic [SYNC_STAGES-1:0][3:0] qd_q;

    // Edges compare the sample entering the last stage with the one leaving it,
    // so each edge flag lines up with the matching QD sample in qd_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            qck_q     <= '1;
            qss_q     <= '1;
            vld_q     <= '0;
            qd_q      <= '0;
            qrise_o   <= 1'b0;
            qfall_o   <= 1'b0;
            ss_rise_o <= 1'b0;
        end else begin
            qck_q     <= {qck_q[SYNC_STAGES-2:0], qck_i};
            qss_q     <= {qss_q[SYNC_STAGES-2:0], qss_i};
            vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            qd_q      <= {qd_q[SYNC_STAGES-2:0], qd_i};
            qrise_o   <= vld_q[SYNC_STAGES-1] &  qck_q[SYNC_STAGES-2] & ~qck_q[SYNC_STAGES-1];
            qfall_o   <= vld_q[SYNC_STAGES-1] & ~qck_q[SYNC_STAGES-2] &  qck_q[SYNC_STAGES-1];
            ss_rise_o <= vld_q[SYNC_STAGES-1] &  qss_q[SYNC_STAGES-2] & ~qss_q[SYNC_STAGES-1];
        end
    end

    assign valid_o = vld_q[SYNC_STAGES-1];
    assign qss_o   = qss_q[SYNC_STAGES-1];
    assign qd_o    = qd_q[SYNC_STAGES-1];

endmodule

// File: rtl/qspi_slave_framer.sv
// Oversampled QSPI mode-3 slave: command byte, then a write stream or a
// dummy-delayed read stream fed from a single-byte holding register.
module qspi_slave_framer
    import qspi_pkg::*;
#(
    parameter int unsigned DWIDTH       = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       QCK,
    input  logic       QSS,
    input  logic [3:0] QD_IN,
    output logic [3:0] QD_OUT,
    output logic [3:0] QD_OE,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_cmd,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       underrun,
    output logic       frame_end
);

    if (!(DWIDTH == 1 || DWIDTH == 2 || DWIDTH == 4)) begin : g_bad_dwidth
        $error("qspi_slave_framer: DWIDTH must be 1, 2 or 4");
    end
    if (DUMMY_CYCLES > 15) begin : g_bad_dummy
        $error("qspi_slave_framer: DUMMY_CYCLES must be 0..15");
    end

    localparam int unsigned DPB       = digits_per_byte(DWIDTH);
    localparam logic [3:0]  LANE_MASK = 4'((1 << DWIDTH) - 1);

    logic       s_valid, s_qss, s_qrise, s_qfall, s_ss_rise;
    logic [3:0] s_qd;
    logic       unused_qd;

    qspi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .qck_i     (QCK),
        .qss_i     (QSS),
        .qd_i      (QD_IN),
        .valid_o   (s_valid),
        .qss_o     (s_qss),
        .qrise_o   (s_qrise),
        .qfall_o   (s_qfall),
        .ss_rise_o (s_ss_rise),
        .qd_o      (s_qd)
    );

    assign unused_qd = ^s_qd;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] dummy_q, dummy_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       underrun_q, underrun_d;
    logic       armed_q, armed_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_cmd_q, rx_cmd_d;
    logic       frame_end_q, frame_end_d;
    logic       busy_q, busy_d;
    logic       tx_ready_q, tx_ready_d;
    logic [3:0] qd_out_q, qd_out_d;
    logic [3:0] qd_oe_q, qd_oe_d;
    logic [7:0] rx_byte;
    logic       load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            dummy_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            armed_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_cmd_q    <= 1'b0;
            frame_end_q <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            qd_out_q    <= '0;
            qd_oe_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            dummy_q     <= dummy_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            armed_q     <= armed_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_cmd_q    <= rx_cmd_d;
            frame_end_q <= frame_end_d;
            busy_q      <= busy_d;
            tx_ready_q  <= tx_ready_d;
            qd_out_q    <= qd_out_d;
            qd_oe_q     <= qd_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        dummy_d     = dummy_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_cmd_d    = 1'b0;
        frame_end_d = 1'b0;
        load        = 1'b0;
        rx_byte     = (shreg_q << DWIDTH) | 8'(s_qd[DWIDTH-1:0]);
        // A frame may only start once QSS has been seen high since reset.
        armed_d     = armed_q | (s_valid & s_qss);

        unique case (state_q)
            IDLE: begin
                if (s_valid && armed_q && !s_qss) begin
                    state_d    = CMD;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                end
            end
            CMD, WRITE: begin
                if (s_qrise) begin
                    shreg_d = rx_byte;
                    if (cnt_q == 3'(DPB - 1)) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                        if (state_q == CMD) begin
                            rx_cmd_d = 1'b1;
                            if (rx_byte[CMD_READ_BIT]) begin
                                state_d = DUMMY;
                                dummy_d = 4'(DUMMY_CYCLES);
                            end else begin
                                state_d = WRITE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            DUMMY: begin
                if (s_qrise && dummy_q != 4'd0) begin
                    dummy_d = dummy_q - 4'd1;
                end else if (s_qfall && dummy_q == 4'd0) begin
                    load    = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (s_qfall) begin
                    if (cnt_q == 3'(DPB - 1)) begin
                        load = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        shreg_d = shreg_q << DWIDTH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cnt_d = '0;
            if (hold_full_q) begin
                shreg_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shreg_d    = UNDERRUN_FILL;
                underrun_d = 1'b1;
            end
        end

        // Fill after load so a same-cycle load sees the old holding contents.
        if (tx_valid && tx_ready_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        // Deselect wins over everything except reporting a just-completed rx byte.
        if (s_ss_rise) begin
            state_d     = IDLE;
            hold_full_d = 1'b0;
            frame_end_d = 1'b1;
        end

        busy_d     = (state_d != IDLE);
        tx_ready_d = !hold_full_d && (state_d == DUMMY || state_d == READ);
        qd_oe_d    = (state_d == READ) ? LANE_MASK : 4'h0;
        qd_out_d   = (state_d == READ) ? 4'(shreg_d[7 -: DWIDTH]) : 4'h0;
    end

    assign QD_OUT    = qd_out_q;
    assign QD_OE     = qd_oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_cmd    = rx_cmd_q;
    assign tx_ready  = tx_ready_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_qspi_slave_framer.sv
// Drives a QSPI master against 4-lane and 1-lane framers and checks bytes, flags and lane enables.
module tb_qspi_slave_framer;

    localparam int unsigned HALF   = 4;
    localparam int unsigned NDUMMY = 2;

    logic       clk = 1'b0;
    logic       rst, QCK, QSS;
    logic [3:0] QD_IN;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic [3:0] qd_out4, qd_oe4, qd_out1, qd_oe1;
    logic [7:0] rx_data4, rx_data1;
    logic       rx_valid4, rx_cmd4, tx_ready4, busy4, underrun4, frame_end4;
    logic       rx_valid1, rx_cmd1, tx_ready1, busy1, underrun1, frame_end1;

    logic       sel1;
    int         dw;
    logic [3:0] qd_out_m, qd_oe_m;
    logic [7:0] rx_data_m;
    logic       rx_valid_m, rx_cmd_m, tx_ready_m, busy_m, underrun_m, frame_end_m;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [8:0] rx_log [256];
    int         rx_n   = 0;
    int         oe_n   = 0;
    int         fe_n   = 0;
    logic [7:0] tx_src [$];
    logic [7:0] wbuf   [8];
    logic [7:0] sbuf   [8];

    always #5 clk = ~clk;

    qspi_slave_framer #(.DWIDTH(4), .SYNC_STAGES(2), .DUMMY_CYCLES(NDUMMY)) u_dut4 (
        .clk(clk), .rst(rst), .QCK(QCK), .QSS(QSS), .QD_IN(QD_IN),
        .QD_OUT(qd_out4), .QD_OE(qd_oe4), .rx_data(rx_data4), .rx_valid(rx_valid4),
        .rx_cmd(rx_cmd4), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready4),
        .busy(busy4), .underrun(underrun4), .frame_end(frame_end4)
    );

    qspi_slave_framer #(.DWIDTH(1), .SYNC_STAGES(2), .DUMMY_CYCLES(NDUMMY)) u_dut1 (
        .clk(clk), .rst(rst), .QCK(QCK), .QSS(QSS), .QD_IN(QD_IN),
        .QD_OUT(qd_out1), .QD_OE(qd_oe1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_cmd(rx_cmd1), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready1),
        .busy(busy1), .underrun(underrun1), .frame_end(frame_end1)
    );

    assign qd_out_m    = sel1 ? qd_out1    : qd_out4;
    assign qd_oe_m     = sel1 ? qd_oe1     : qd_oe4;
    assign rx_data_m   = sel1 ? rx_data1   : rx_data4;
    assign rx_valid_m  = sel1 ? rx_valid1  : rx_valid4;
    assign rx_cmd_m    = sel1 ? rx_cmd1    : rx_cmd4;
    assign tx_ready_m  = sel1 ? tx_ready1  : tx_ready4;
    assign busy_m      = sel1 ? busy1      : busy4;
    assign underrun_m  = sel1 ? underrun1  : underrun4;
    assign frame_end_m = sel1 ? frame_end1 : frame_end4;

    // Event log of the selected DUT, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rx_valid_m) begin
            rx_log[rx_n % 256] <= {rx_cmd_m, rx_data_m};
            rx_n <= rx_n + 1;
        end
        if (qd_oe_m != 4'h0) oe_n <= oe_n + 1;
        if (frame_end_m)     fe_n <= fe_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] lane_mask();
        return 4'((1 << dw) - 1);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offers queued bytes on tx_valid/tx_data and pops each one the DUT accepts.
    task automatic tx_feeder();
        logic acc;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(posedge clk);
            acc = tx_valid && tx_ready_m;
            @(negedge clk);
            if (acc && tx_src.size() > 0) void'(tx_src.pop_front());
            tx_valid = (tx_src.size() > 0);
            if (tx_valid) tx_data = tx_src[0];
        end
    endtask

    task automatic send_digit(input logic [3:0] d);
        logic [3:0] junk;
        junk  = 4'($urandom);
        QCK   = 1'b0;
        QD_IN = (junk & ~lane_mask()) | (d & lane_mask());
        wait_clks(HALF);
        QCK = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 0; k < 8 / dw; k++)
            send_digit(4'((b >> (8 - dw * (k + 1))) & ((1 << dw) - 1)));
    endtask

    task automatic recv_byte(output logic [7:0] b);
        b = 8'h00;
        for (int k = 0; k < 8 / dw; k++) begin
            QCK = 1'b0;
            wait_clks(HALF);
            check("qd_oe_read", 32'(qd_oe_m), 32'(lane_mask()));
            check("qd_out_idle_lanes", 32'(qd_out_m & ~lane_mask()), 32'h0);
            b   = (b << dw) | 8'(qd_out_m & lane_mask());
            QCK = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic dummy_clks(input int n);
        for (int k = 0; k < n; k++) begin
            QCK = 1'b0;
            wait_clks(HALF);
            QCK = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic frame_begin();
        QSS = 1'b0;
        wait_clks(2 * HALF);
        check("busy_at_start", 32'(busy_m), 32'h1);
        check("underrun_cleared_at_start", 32'(underrun_m), 32'h0);
    endtask

    task automatic frame_finish();
        QSS = 1'b1;
        wait_clks(3 * HALF);
        check("busy_after_end", 32'(busy_m), 32'h0);
    endtask

    // Expected: one command entry, then each written byte in order; no lane ever enabled.
    task automatic run_write(input logic [7:0] cmd, input int n);
        int rx0, oe0, fe0;
        rx0 = rx_n; oe0 = oe_n; fe0 = fe_n;
        frame_begin();
        send_byte(cmd);
        for (int i = 0; i < n; i++) send_byte(wbuf[i]);
        frame_finish();
        check("wr_rx_count", 32'(rx_n - rx0), 32'(n + 1));
        check("wr_cmd_entry", 32'(rx_log[rx0 % 256]), 32'({1'b1, cmd}));
        for (int i = 0; i < n; i++)
            check("wr_data_entry", 32'(rx_log[(rx0 + 1 + i) % 256]), 32'({1'b0, wbuf[i]}));
        check("wr_qd_oe_never", 32'(oe_n - oe0), 32'h0);
        check("wr_frame_end", 32'(fe_n - fe0), 32'h1);
    endtask

    // Expected: the supplied bytes in order, then 0x00 fill; underrun iff reads outnumber supplies.
    task automatic run_read(input logic [7:0] cmd, input int nrd, input int nsup);
        int rx0;
        logic [7:0] b;
        rx0 = rx_n;
        for (int i = 0; i < nsup; i++) tx_src.push_back(sbuf[i]);
        frame_begin();
        send_byte(cmd);
        dummy_clks(NDUMMY);
        for (int i = 0; i < nrd; i++) begin
            recv_byte(b);
            check("rd_byte", 32'(b), 32'((i < nsup) ? sbuf[i] : 8'h00));
        end
        frame_finish();
        tx_src.delete();
        check("rd_underrun", 32'(underrun_m), 32'(nrd > nsup));
        check("rd_rx_count", 32'(rx_n - rx0), 32'h1);
        check("rd_cmd_entry", 32'(rx_log[rx0 % 256]), 32'({1'b1, cmd}));
        check("rd_tx_ready_idle", 32'(tx_ready_m), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $error("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx0, oe0, fe0, n, nrd, nsup;
        logic [7:0] b;
        rst = 1'b1; QCK = 1'b1; QSS = 1'b1; QD_IN = 4'h0;
        sel1 = 1'b0; dw = 4;
        fork tx_feeder(); join_none
        wait_clks(3);
        check("rst_rx_valid", 32'(rx_valid_m), 32'h0);
        check("rst_rx_data", 32'(rx_data_m), 32'h0);
        check("rst_qd_oe", 32'(qd_oe_m), 32'h0);
        check("rst_qd_out", 32'(qd_out_m), 32'h0);
        check("rst_tx_ready", 32'(tx_ready_m), 32'h0);
        check("rst_flags", 32'({busy_m, underrun_m, frame_end_m, rx_cmd_m}), 32'h0);
        rst = 1'b0;
        wait_clks(8);

        // 4-lane write frame
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        run_write(8'h12, 2);

        // 4-lane read, fully supplied
        sbuf[0] = 8'h5A; sbuf[1] = 8'hC3;
        run_read(8'h80, 2, 2);

        // 4-lane read with underrun; flag must persist until the next frame starts
        sbuf[0] = 8'h77;
        run_read(8'h80, 3, 1);
        wait_clks(10);
        check("underrun_sticky_idle", 32'(underrun_m), 32'h1);

        // 1-lane write frame
        sel1 = 1'b1; dw = 1;
        wbuf[0] = 8'h96;
        run_write(8'h01, 1);

        // 1-lane deselect after 5 bits of a data byte
        rx0 = rx_n; fe0 = fe_n;
        frame_begin();
        send_byte(8'h01);
        for (int k = 0; k < 5; k++) send_digit(4'(k & 1));
        frame_finish();
        check("partial_rx_count", 32'(rx_n - rx0), 32'h1);
        check("partial_frame_end", 32'(fe_n - fe0), 32'h1);
        wbuf[0] = 8'h4E;
        run_write(8'h2B, 1);

        // Reset in the middle of a 4-lane read
        sel1 = 1'b0; dw = 4;
        tx_src.push_back(8'h11); tx_src.push_back(8'h22);
        frame_begin();
        send_byte(8'h81);
        dummy_clks(NDUMMY);
        recv_byte(b);
        check("mid_rst_first_byte", 32'(b), 32'h11);
        rst = 1'b1;
        wait_clks(1);
        check("mid_rst_qd_oe", 32'(qd_oe_m), 32'h0);
        check("mid_rst_tx_ready", 32'(tx_ready_m), 32'h0);
        rst = 1'b0;
        tx_src.delete();
        rx0 = rx_n; oe0 = oe_n;
        send_byte(8'h3C);
        send_byte(8'h81);
        check("post_rst_no_rx", 32'(rx_n - rx0), 32'h0);
        check("post_rst_no_oe", 32'(oe_n - oe0), 32'h0);
        check("post_rst_not_busy", 32'(busy_m), 32'h0);
        QSS = 1'b1;
        wait_clks(3 * HALF);
        wbuf[0] = 8'hE7;
        run_write(8'h55, 1);

        // Randomised frames on either DUT
        for (int f = 0; f < 14; f++) begin
            sel1 = ($urandom_range(0, 1) == 1);
            dw   = sel1 ? 1 : 4;
            if ($urandom_range(0, 1) == 1) begin
                n = int'($urandom_range(0, 4));
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                run_write(8'($urandom_range(0, 127)), n);
            end else begin
                nrd  = int'($urandom_range(1, 3));
                nsup = int'($urandom_range(0, nrd));
                for (int i = 0; i < nsup; i++) sbuf[i] = 8'($urandom);
                run_read(8'(8'h80 | 8'($urandom_range(0, 127))), nrd, nsup);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/qspi_slave_framer.md
Name: qspi_slave_framer

Overview:
Single-clock QSPI slave (mode 3) that oversamples QCK/QSS/QD in the system clock domain. Each frame carries a command byte, then either a master-to-slave write stream or a slave-to-master read stream. The read stream starts after a configurable number of turnaround (dummy) clocks. Sits between the board QSPI pins (external tri-state buffer) and a byte-stream consumer/producer in the clk domain; supersedes the separate QCK-domain rx/tx shifters.

Parameters:
DWIDTH, 4, data lanes used: 1, 2 or 4 (other values: elaboration error)
SYNC_STAGES, 2, synchroniser depth for QCK, QSS and QD_IN (>=2)
DUMMY_CYCLES, 2, QCK rising edges between command and first read digit (0..15)

Ports:
clk  input  1  system clock; QCK frequency must be <= clk/8
rst  input  1  synchronous, active-high reset
QCK  input  1  QSPI clock, idle high
QSS  input  1  QSPI select, active low
QD_IN  input  4  QSPI data lanes, pin input side
QD_OUT  output  4  QSPI data lanes, pin output side
QD_OE  output  4  per-lane output enable
rx_data  output  8  received byte
rx_valid  output  1  one-cycle strobe: rx_data is valid
rx_cmd  output  1  qualifies rx_valid: the byte is the command byte
tx_data  input  8  byte to transmit
tx_valid  input  1  tx_data offered
tx_ready  output  1  holding register empty, read phase active
busy  output  1  frame in progress (synchronised QSS low)
underrun  output  1  sticky per frame: read digit needed with holding register empty
frame_end  output  1  one-cycle strobe on synchronised QSS rising edge

Behaviour:
- One clock (clk), synchronous active-high reset (rst). All state updates on posedge clk.
- Reset: state IDLE; all outputs 0; QD_OE=0; holding register empty; sticky flags cleared.
- Sync: QCK, QSS and QD_IN each pass SYNC_STAGES flops. qrise/qfall = synced QCK 0->1 / 1->0 relative to the previous synced sample. QD is sampled from the same-depth delayed copy, so data and edge stay aligned.
- Bits are MSB first. Lane mapping is QD[DWIDTH-1:0]; DWIDTH=4 sends the high nibble first. 8/DWIDTH digits per byte.
- QD_OE[i]=1 only for i<DWIDTH and only in READ. Unused QD_OUT lanes are 0.
- States:
  IDLE: synced QSS low -> CMD, digit counter 0, busy=1.
  CMD: shift one digit per qrise. On the last digit: rx_data=cmd, rx_valid=1, rx_cmd=1 for one clk. If cmd[7]=0 -> WRITE; otherwise -> DUMMY with counter=DUMMY_CYCLES.
  WRITE: shift per qrise. Each completed byte pulses rx_valid (rx_cmd=0) in the clk after its last qrise. No backpressure.
  DUMMY: QD_OE=0. Decrement per qrise. At 0 (immediately if DUMMY_CYCLES=0), the next qfall loads the shift register and goes to READ.
  READ: QD_OE asserted; the first digit is driven from the qfall that entered READ. Each subsequent qfall advances one digit; after the last digit of a byte, the next qfall loads a new byte.
- Byte load: from the holding register if full, which then becomes empty. If empty, load 8'h00 and set underrun.
- tx handshake: transfer when tx_valid && tx_ready. tx_ready = holding empty && state in {DUMMY, READ}. Only one byte is buffered. A fill in the same clk as a load is allowed: the load uses the old contents.
- Deselect (synced QSS 0->1) in any state:
  - next state IDLE; QD_OE=0 in the same clk; frame_end=1 for one clk.
  - partial rx byte discarded with no rx_valid; holding register flushed.
  - underrun cleared on the next frame start.
- QSS rising and a byte completion in the same clk: the completed rx byte is still reported (rx_valid=1) alongside frame_end.
- Latency: rx_valid follows the last qrise of a byte by 1 clk. QD_OUT changes 1 clk after qfall is detected.
- rst mid-frame: immediate IDLE. The rest of the frame is ignored until QSS is seen high, then low again.

Decomposition:
- Package qspi_pkg: state enum (IDLE, CMD, WRITE, DUMMY, READ), CMD_READ_BIT=7, underrun fill byte 8'h00, and a digits-per-byte function of DWIDTH.
- Sub-module qspi_pin_sync (SYNC_STAGES flop chains, edge detect, aligned QD). The FSM, shifters and holding register stay in qspi_slave_framer.

Test Plan:
- DWIDTH=4: write frame cmd 0x12, then 0xA5, 0x3C -> rx_valid x3. The first has rx_cmd=1, data 0x12; the others have data 0xA5, 0x3C. QD_OE stays 0 throughout.
- DWIDTH=4, DUMMY_CYCLES=2: cmd 0x80; tx 0x5A, 0xC3 preloaded via handshake -> after 2 dummy clocks the master samples nibbles 5,A,C,3; underrun stays 0.
- Read frame of 3 bytes with only 0x77 supplied -> master reads 0x77, 0x00, 0x00; underrun=1 until the next frame start.
- DWIDTH=1: write frame cmd 0x01, then 0x96 on QD[0] -> rx_data 0x01 then 0x96. QD[3:1] are ignored.
- QSS raised after 5 of 8 bits (DWIDTH=1) of a write byte -> no rx_valid; frame_end pulse; IDLE. The next frame's command decodes correctly.
- rst asserted mid-READ -> QD_OE=0 and tx_ready=0 the next clk. Continued QCK is ignored until QSS goes high, then low.
